// File: rtl/is_uart_hex_cmd_parser.sv
// UART hex command parser: turns "w<addr><data>CR" / "r<addr>CR" byte streams into
// register-access commands on a valid/ready handshake, with single-cycle error pulses.
module is_uart_hex_cmd_parser #(
   parameter int DATA_W      = 8,
   parameter int ADDR_NIB    = 2,
   parameter int DATA_NIB    = 4,
   parameter int TIMEOUT_CYC = 1_000_000
) (
   input  logic                  clk_i,
   input  logic                  rst_n_i,
   input  logic [DATA_W-1:0]     rx_data_i,
   input  logic                  rx_vld_i,
   output logic                  cmd_vld_o,
   input  logic                  cmd_rdy_i,
   output logic                  cmd_we_o,
   output logic [4*ADDR_NIB-1:0] cmd_addr_o,
   output logic [4*DATA_NIB-1:0] cmd_wdata_o,
   output logic                  err_o,
   output logic [1:0]            err_code_o,
   output logic                  busy_o
);

   localparam int AW     = 4*ADDR_NIB;
   localparam int DW     = 4*DATA_NIB;
   localparam int NC_MAX = (ADDR_NIB > DATA_NIB) ? ADDR_NIB : DATA_NIB;
   localparam int NC_W   = $clog2(NC_MAX + 1);
   localparam int TO_W   = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_ADDR  = 3'd1;
   localparam logic [2:0] S_DATA  = 3'd2;
   localparam logic [2:0] S_TERM  = 3'd3;
   localparam logic [2:0] S_ISSUE = 3'd4;

   localparam logic [1:0] E_CHAR = 2'd0;
   localparam logic [1:0] E_LEN  = 2'd1;
   localparam logic [1:0] E_OVR  = 2'd2;
   localparam logic [1:0] E_TO   = 2'd3;

   logic [2:0]      state_q, state_d;
   logic [NC_W-1:0] nib_cnt_q, nib_cnt_d;
   logic [TO_W-1:0] to_cnt_q, to_cnt_d;
   logic            vld_q, vld_d;
   logic            we_q, we_d;
   logic [AW-1:0]   addr_q, addr_d;
   logic [DW-1:0]   wdata_q, wdata_d;
   logic            err_q, err_d;
   logic [1:0]      err_code_q, err_code_d;
   logic            busy_q, busy_d;

   logic       is_hex, is_cmd, is_wr, is_term, is_ws, in_cmd, timeout;
   logic [3:0] nib;

   always_comb begin
      is_hex = 1'b0;
      nib    = 4'h0;
      if (rx_data_i >= DATA_W'(8'h30) && rx_data_i <= DATA_W'(8'h39)) begin
         is_hex = 1'b1;
         nib    = 4'(rx_data_i - DATA_W'(8'h30));
      end else if (rx_data_i >= DATA_W'(8'h41) && rx_data_i <= DATA_W'(8'h46)) begin
         is_hex = 1'b1;
         nib    = 4'(rx_data_i - DATA_W'(8'h37));
      end else if (rx_data_i >= DATA_W'(8'h61) && rx_data_i <= DATA_W'(8'h66)) begin
         is_hex = 1'b1;
         nib    = 4'(rx_data_i - DATA_W'(8'h57));
      end
      is_wr   = (rx_data_i == DATA_W'(8'h77)) || (rx_data_i == DATA_W'(8'h57));
      is_cmd  = is_wr || (rx_data_i == DATA_W'(8'h72)) || (rx_data_i == DATA_W'(8'h52));
      is_term = (rx_data_i == DATA_W'(8'h0D)) || (rx_data_i == DATA_W'(8'h0A));
      is_ws   = (rx_data_i == DATA_W'(8'h20));
   end

   assign in_cmd  = (state_q == S_ADDR) || (state_q == S_DATA) || (state_q == S_TERM);
   assign timeout = in_cmd && !rx_vld_i && (to_cnt_q == TO_W'(TIMEOUT_CYC - 1));

   always_comb begin
      state_d    = state_q;
      nib_cnt_d  = nib_cnt_q;
      we_d       = we_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      err_d      = 1'b0;
      err_code_d = err_code_q;
      to_cnt_d   = (in_cmd && !rx_vld_i) ? to_cnt_q + 1'b1 : '0;

      if (timeout) begin
         err_d      = 1'b1;
         err_code_d = E_TO;
         state_d    = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE: if (rx_vld_i) begin
               if (is_cmd) begin
                  we_d      = is_wr;
                  addr_d    = '0;
                  wdata_d   = '0;
                  nib_cnt_d = '0;
                  state_d   = S_ADDR;
               end else if (!is_term && !is_ws) begin
                  err_d      = 1'b1;
                  err_code_d = E_CHAR;
               end
            end
            S_ADDR, S_DATA: if (rx_vld_i) begin
               if (is_hex) begin
                  nib_cnt_d = nib_cnt_q + 1'b1;
                  if (state_q == S_ADDR) begin
                     addr_d = (addr_q << 4) | AW'(nib);
                     if (nib_cnt_q == NC_W'(ADDR_NIB - 1)) begin
                        nib_cnt_d = '0;
                        state_d   = we_q ? S_DATA : S_TERM;
                     end
                  end else begin
                     wdata_d = (wdata_q << 4) | DW'(nib);
                     if (nib_cnt_q == NC_W'(DATA_NIB - 1)) begin
                        nib_cnt_d = '0;
                        state_d   = S_TERM;
                     end
                  end
               end else begin
                  err_d      = 1'b1;
                  err_code_d = is_term ? E_LEN : E_CHAR;
                  state_d    = S_IDLE;
               end
            end
            S_TERM: if (rx_vld_i) begin
               if (is_term) begin
                  state_d = S_ISSUE;
               end else begin
                  err_d      = 1'b1;
                  err_code_d = is_hex ? E_LEN : E_CHAR;
                  state_d    = S_IDLE;
               end
            end
            S_ISSUE: begin
               if (vld_q && cmd_rdy_i) state_d = S_IDLE;
               // Stray bytes while a command waits are dropped; CR/LF/space are expected filler.
               if (rx_vld_i && !is_term && !is_ws) begin
                  err_d      = 1'b1;
                  err_code_d = E_OVR;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end

      vld_d  = (state_d == S_ISSUE);
      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         state_q    <= S_IDLE;
         nib_cnt_q  <= '0;
         to_cnt_q   <= '0;
         vld_q      <= 1'b0;
         we_q       <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         err_q      <= 1'b0;
         err_code_q <= 2'd0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         nib_cnt_q  <= nib_cnt_d;
         to_cnt_q   <= to_cnt_d;
         vld_q      <= vld_d;
         we_q       <= we_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         err_q      <= err_d;
         err_code_q <= err_code_d;
         busy_q     <= busy_d;
      end
   end

   assign cmd_vld_o   = vld_q;
   assign cmd_we_o    = we_q;
   assign cmd_addr_o  = addr_q;
   assign cmd_wdata_o = wdata_q;
   assign err_o       = err_q;
   assign err_code_o  = err_code_q;
   assign busy_o      = busy_q;

endmodule

// File: tb/tb_is_uart_hex_cmd_parser.sv
// Directed bench for is_uart_hex_cmd_parser; a negedge monitor tallies pulses and accepted commands.
module tb_is_uart_hex_cmd_parser;

   logic        clk_i = 1'b0;
   logic        rst_n_i = 1'b0;
   logic [7:0]  rx_data_i = 8'h00;
   logic        rx_vld_i = 1'b0;
   logic        cmd_vld_o;
   logic        cmd_rdy_i = 1'b0;
   logic        cmd_we_o;
   logic [7:0]  cmd_addr_o;
   logic [15:0] cmd_wdata_o;
   logic        err_o;
   logic [1:0]  err_code_o;
   logic        busy_o;

   is_uart_hex_cmd_parser #(
      .DATA_W(8), .ADDR_NIB(2), .DATA_NIB(4), .TIMEOUT_CYC(16)
   ) dut (
      .clk_i(clk_i), .rst_n_i(rst_n_i), .rx_data_i(rx_data_i), .rx_vld_i(rx_vld_i),
      .cmd_vld_o(cmd_vld_o), .cmd_rdy_i(cmd_rdy_i), .cmd_we_o(cmd_we_o),
      .cmd_addr_o(cmd_addr_o), .cmd_wdata_o(cmd_wdata_o), .err_o(err_o),
      .err_code_o(err_code_o), .busy_o(busy_o)
   );

   always #5 clk_i = ~clk_i;

   int          n_tests = 0;
   int          n_fail  = 0;

   // Monitor state (only written here)
   int          err_cnt = 0;
   logic [1:0]  last_code = 2'd0;
   int          vld_cyc = 0;
   int          acc_cnt = 0;
   logic        acc_we = 1'b0;
   logic [7:0]  acc_addr = 8'h00;
   logic [15:0] acc_wdata = 16'h0;
   int          stab_err = 0;
   logic        p_vld = 1'b0, p_acc = 1'b0, p_we = 1'b0;
   logic [7:0]  p_addr = 8'h00;
   logic [15:0] p_wdata = 16'h0;

   always @(negedge clk_i) begin
      if (err_o) begin
         err_cnt   <= err_cnt + 1;
         last_code <= err_code_o;
      end
      if (cmd_vld_o) vld_cyc <= vld_cyc + 1;
      if (cmd_vld_o && cmd_rdy_i) begin
         acc_cnt   <= acc_cnt + 1;
         acc_we    <= cmd_we_o;
         acc_addr  <= cmd_addr_o;
         acc_wdata <= cmd_wdata_o;
      end
      if (cmd_vld_o && p_vld && !p_acc &&
          (cmd_we_o != p_we || cmd_addr_o != p_addr || cmd_wdata_o != p_wdata))
         stab_err <= stab_err + 1;
      p_vld   <= cmd_vld_o;
      p_acc   <= cmd_vld_o && cmd_rdy_i;
      p_we    <= cmd_we_o;
      p_addr  <= cmd_addr_o;
      p_wdata <= cmd_wdata_o;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk_i);
         #1;
      end
   endtask

   task automatic put(input logic [7:0] b);
      rx_data_i = b;
      rx_vld_i  = 1'b1;
      tick(1);
      rx_vld_i  = 1'b0;
   endtask

   task automatic puts(input string s);
      for (int i = 0; i < s.len(); i++) put(s[i]);
   endtask

   int e0, v0, a0;

   task automatic snap();
      e0 = err_cnt;
      v0 = vld_cyc;
      a0 = acc_cnt;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_vld"},   32'(cmd_vld_o),   32'd0);
      chk({tag, "_we"},    32'(cmd_we_o),    32'd0);
      chk({tag, "_addr"},  32'(cmd_addr_o),  32'd0);
      chk({tag, "_wdata"}, 32'(cmd_wdata_o), 32'd0);
      chk({tag, "_err"},   32'(err_o),       32'd0);
      chk({tag, "_busy"},  32'(busy_o),      32'd0);
   endtask

   initial begin
      tick(2);
      chk_all_zero("rst");
      chk("rst_code", 32'(err_code_o), 32'd0);
      rst_n_i = 1'b1;
      tick(1);

      // Full write, consumer ready
      cmd_rdy_i = 1'b1;
      snap();
      puts("w1Aff03\r");
      tick(3);
      chk("wr_vld_cycles", 32'(vld_cyc - v0), 32'd1);
      chk("wr_acc",        32'(acc_cnt - a0), 32'd1);
      chk("wr_we",         32'(acc_we),       32'd1);
      chk("wr_addr",       32'(acc_addr),     32'h1A);
      chk("wr_wdata",      32'(acc_wdata),    32'hFF03);
      chk("wr_noerr",      32'(err_cnt - e0), 32'd0);
      chk("wr_busy",       32'(busy_o),       32'd0);

      // Read with CRLF and 5 stalled cycles
      cmd_rdy_i = 1'b0;
      snap();
      puts("R7f\r\n");
      tick(4);
      cmd_rdy_i = 1'b1;
      tick(1);
      cmd_rdy_i = 1'b0;
      tick(2);
      chk("rd_vld_cycles", 32'(vld_cyc - v0), 32'd6);
      chk("rd_acc",        32'(acc_cnt - a0), 32'd1);
      chk("rd_we",         32'(acc_we),       32'd0);
      chk("rd_addr",       32'(acc_addr),     32'h7F);
      chk("rd_wdata",      32'(acc_wdata),    32'h0);
      chk("rd_lf_noerr",   32'(err_cnt - e0), 32'd0);

      snap();
      puts("w1G");
      tick(2);
      chk("badchar_cnt",  32'(err_cnt - e0), 32'd1);
      chk("badchar_code", 32'(last_code),    32'd0);
      chk("badchar_busy", 32'(busy_o),       32'd0);

      snap();
      puts("w12\r");
      tick(2);
      chk("short_cnt",  32'(err_cnt - e0), 32'd1);
      chk("short_code", 32'(last_code),    32'd1);
      chk("short_vld",  32'(vld_cyc - v0), 32'd0);

      snap();
      puts("r123");
      tick(2);
      chk("long_cnt",  32'(err_cnt - e0), 32'd1);
      chk("long_code", 32'(last_code),    32'd1);
      chk("long_busy", 32'(busy_o),       32'd0);

      // Overrun while a write waits; the command must survive intact
      snap();
      puts("w5A1234\r");
      tick(1);
      put("w");
      tick(2);
      chk("ovr_cnt",  32'(err_cnt - e0), 32'd1);
      chk("ovr_code", 32'(last_code),    32'd2);
      chk("ovr_still_vld", 32'(cmd_vld_o), 32'd1);
      cmd_rdy_i = 1'b1;
      tick(1);
      cmd_rdy_i = 1'b0;
      tick(1);
      chk("ovr_acc",   32'(acc_cnt - a0), 32'd1);
      chk("ovr_we",    32'(acc_we),       32'd1);
      chk("ovr_addr",  32'(acc_addr),     32'h5A);
      chk("ovr_wdata", 32'(acc_wdata),    32'h1234);

      snap();
      put("x");
      tick(2);
      chk("junk_cnt",  32'(err_cnt - e0), 32'd1);
      chk("junk_code", 32'(last_code),    32'd0);

      // Timeout after 16 idle cycles
      snap();
      puts("w1");
      tick(15);
      chk("to_pre_busy", 32'(busy_o),       32'd1);
      chk("to_pre_err",  32'(err_cnt - e0), 32'd0);
      tick(3);
      chk("to_cnt",  32'(err_cnt - e0), 32'd1);
      chk("to_code", 32'(last_code),    32'd3);
      chk("to_busy", 32'(busy_o),       32'd0);

      // Byte in the last allowed cycle is accepted
      snap();
      puts("r1");
      tick(15);
      put("A");
      chk("to_edge_busy", 32'(busy_o),       32'd1);
      tick(2);
      chk("to_edge_noerr", 32'(err_cnt - e0), 32'd0);
      cmd_rdy_i = 1'b1;
      put("\r");
      tick(3);
      cmd_rdy_i = 1'b0;
      chk("to_edge_acc",  32'(acc_cnt - a0), 32'd1);
      chk("to_edge_addr", 32'(acc_addr),     32'h1A);

      // Reset mid-command
      snap();
      puts("w1A");
      rst_n_i = 1'b0;
      tick(1);
      chk_all_zero("mid_rst");
      rst_n_i = 1'b1;
      tick(2);
      chk("mid_rst_noerr", 32'(err_cnt - e0), 32'd0);
      cmd_rdy_i = 1'b1;
      puts("r00\r");
      tick(3);
      cmd_rdy_i = 1'b0;
      chk("post_rst_acc",  32'(acc_cnt - a0), 32'd1);
      chk("post_rst_we",   32'(acc_we),       32'd0);
      chk("post_rst_addr", 32'(acc_addr),     32'h00);

      chk("payload_stable", 32'(stab_err), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
